// File: rtl/btb_assoc_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// btb_assoc_if : fetch lookup / EX update bundle for the branch target buffer
// Rev 1.0
// -----------------------------------------------------------------------------
interface btb_assoc_if #(
  parameter int ADDR_W = 16
);
  logic              lu_valid;
  logic [ADDR_W-1:0] lu_pc;
  logic              pred_valid;
  logic              pred_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              up_valid;
  logic              up_is_br;
  logic [ADDR_W-1:0] up_pc;
  logic              up_taken;
  logic [ADDR_W-1:0] up_target;
  logic              up_pred_taken;

  modport master (
    output lu_valid, lu_pc,
    output up_valid, up_is_br, up_pc, up_taken, up_target, up_pred_taken,
    input  pred_valid, pred_hit, pred_taken, pred_target
  );

  modport slave (
    input  lu_valid, lu_pc,
    input  up_valid, up_is_br, up_pc, up_taken, up_target, up_pred_taken,
    output pred_valid, pred_hit, pred_taken, pred_target
  );
endinterface
`default_nettype wire

// File: rtl/btb_assoc.sv
`default_nettype none
// -----------------------------------------------------------------------------
// btb_assoc : set-associative BTB with saturating direction counters, per-set
//             LRU, post-reset/flush invalidate sweep and saturating statistics
// Rev 1.0
// -----------------------------------------------------------------------------
module btb_assoc #(
  parameter int ADDR_W = 16,
  parameter int SETS   = 256,
  parameter int WAYS   = 2,
  parameter int CTR_W  = 2,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  btb_assoc_if.slave        bus,
  input  logic              flush_all,
  output logic              busy,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] br_cnt,
  output logic [STAT_W-1:0] hit_cnt,
  output logic [STAT_W-1:0] mispr_cnt
);

  localparam int                 c_idx_w    = $clog2(SETS);
  localparam int                 c_tag_w    = ADDR_W - c_idx_w;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(SETS - 1);
  localparam logic [CTR_W-1:0]   c_ctr_max  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0]   c_ctr_init = CTR_W'(1) << (CTR_W - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_idx_w-1:0] r_sweep_idx;
  logic [c_idx_w-1:0] w_sweep_nxt;

  // ---------------------------------------------------------------------------
  // Invalidate sweep FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_sweep_idx <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_idx <= w_sweep_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sweep_nxt = r_sweep_idx;
    case (r_state)
      ST_INIT: begin
        w_sweep_nxt = r_sweep_idx + c_idx_w'(1);
        if (r_sweep_idx == c_last_idx) begin
          w_state_nxt = ST_RUN;
          w_sweep_nxt = '0;
        end
      end
      default: begin
        if (flush_all) begin
          w_state_nxt = ST_INIT;
          w_sweep_nxt = '0;
        end
      end
    endcase
  end

  assign busy = (r_state == ST_INIT);

  // ---------------------------------------------------------------------------
  // Address split
  // ---------------------------------------------------------------------------
  logic [c_idx_w-1:0] w_lu_idx;
  logic [c_tag_w-1:0] w_lu_tag;
  logic [c_idx_w-1:0] w_up_idx;
  logic [c_tag_w-1:0] w_up_tag;

  assign w_lu_idx = bus.lu_pc[c_idx_w-1:0];
  assign w_lu_tag = bus.lu_pc[ADDR_W-1:c_idx_w];
  assign w_up_idx = bus.up_pc[c_idx_w-1:0];
  assign w_up_tag = bus.up_pc[ADDR_W-1:c_idx_w];

  // ---------------------------------------------------------------------------
  // Per-way storage and read ports
  // ---------------------------------------------------------------------------
  logic [WAYS-1:0]             w_lu_hit;
  logic [WAYS-1:0]             w_lu_msb;
  logic [WAYS-1:0][ADDR_W-1:0] w_lu_tgt;
  logic [WAYS-1:0]             w_up_vld;
  logic [WAYS-1:0]             w_up_hit;
  logic [WAYS-1:0][CTR_W-1:0]  w_up_ctr;

  logic            w_up_en;
  logic            w_up_any;
  logic [WAYS-1:0] w_hit_oh;
  logic [CTR_W-1:0] w_hit_ctr;
  logic [CTR_W-1:0] w_ctr_nxt;
  logic            w_free_any;
  logic [WAYS-1:0] w_free_oh;
  logic [WAYS-1:0] w_lru_oh;
  logic [WAYS-1:0] w_alloc_oh;
  logic [WAYS-1:0] w_touch_oh;
  logic            w_hit_we;
  logic            w_alloc_we;
  logic            w_lru_rd;
  logic            w_lru_new;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    logic               r_vld [SETS];
    logic [c_tag_w-1:0] r_tag [SETS];
    logic [CTR_W-1:0]   r_ctr [SETS];
    logic [ADDR_W-1:0]  r_tgt [SETS];

    assign w_lu_hit[g] = r_vld[w_lu_idx] && (r_tag[w_lu_idx] == w_lu_tag);
    assign w_lu_msb[g] = r_ctr[w_lu_idx][CTR_W-1];
    assign w_lu_tgt[g] = r_tgt[w_lu_idx];
    assign w_up_vld[g] = r_vld[w_up_idx];
    assign w_up_hit[g] = r_vld[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_up_ctr[g] = r_ctr[w_up_idx];

    // No reset on the arrays: the sweep owns the valid bits after rst.
    always_ff @(posedge clk) begin
      if (busy) begin
        r_vld[r_sweep_idx] <= 1'b0;
      end else if (w_alloc_we && w_alloc_oh[g]) begin
        r_vld[w_up_idx] <= 1'b1;
        r_tag[w_up_idx] <= w_up_tag;
        r_ctr[w_up_idx] <= c_ctr_init;
        r_tgt[w_up_idx] <= bus.up_target;
      end else if (w_hit_we && w_hit_oh[g]) begin
        r_ctr[w_up_idx] <= w_ctr_nxt;
        if (bus.up_taken) begin
          r_tgt[w_up_idx] <= bus.up_target;
        end
      end
    end
  end

  if (WAYS == 2) begin : g_lru
    logic r_lru [SETS];

    assign w_lru_rd = r_lru[w_up_idx];

    always_ff @(posedge clk) begin
      if (busy) begin
        r_lru[r_sweep_idx] <= 1'b0;
      end else if (w_hit_we || w_alloc_we) begin
        r_lru[w_up_idx] <= w_lru_new;
      end
    end
  end else begin : g_no_lru
    assign w_lru_rd = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Update path: hit detection, victim choice, counter saturation
  // ---------------------------------------------------------------------------
  always_comb begin
    w_up_en    = bus.up_valid && bus.up_is_br && !busy;
    w_up_any   = 1'b0;
    w_hit_oh   = '0;
    w_hit_ctr  = '0;
    w_free_any = 1'b0;
    w_free_oh  = '0;
    w_lru_oh   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (w_up_hit[w] && !w_up_any) begin
        w_up_any    = 1'b1;
        w_hit_oh[w] = 1'b1;
        w_hit_ctr   = w_up_ctr[w];
      end
      if (!w_up_vld[w] && !w_free_any) begin
        w_free_any   = 1'b1;
        w_free_oh[w] = 1'b1;
      end
      w_lru_oh[w] = (WAYS == 1) || (w_lru_rd == 1'(w));
    end
    w_alloc_oh = w_free_any ? w_free_oh : w_lru_oh;
    w_touch_oh = w_up_any ? w_hit_oh : w_alloc_oh;
    // With two ways the victim becomes whichever way was not just touched.
    w_lru_new  = ~w_touch_oh[WAYS-1];
    w_hit_we   = w_up_en && w_up_any;
    w_alloc_we = w_up_en && !w_up_any && bus.up_taken;
  end

  always_comb begin
    w_ctr_nxt = w_hit_ctr;
    if (bus.up_taken) begin
      if (w_hit_ctr != c_ctr_max) begin
        w_ctr_nxt = w_hit_ctr + CTR_W'(1);
      end
    end else if (w_hit_ctr != '0) begin
      w_ctr_nxt = w_hit_ctr - CTR_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Lookup path: registered prediction
  // ---------------------------------------------------------------------------
  logic              w_lu_any;
  logic              w_lu_sel_msb;
  logic [ADDR_W-1:0] w_lu_sel_tgt;
  logic              w_pred_hit;

  always_comb begin
    w_lu_any     = 1'b0;
    w_lu_sel_msb = 1'b0;
    w_lu_sel_tgt = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (w_lu_hit[w] && !w_lu_any) begin
        w_lu_any     = 1'b1;
        w_lu_sel_msb = w_lu_msb[w];
        w_lu_sel_tgt = w_lu_tgt[w];
      end
    end
    w_pred_hit = bus.lu_valid && !busy && w_lu_any;
  end

  logic              r_pred_valid;
  logic              r_pred_hit;
  logic              r_pred_taken;
  logic [ADDR_W-1:0] r_pred_target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pred_valid  <= 1'b0;
      r_pred_hit    <= 1'b0;
      r_pred_taken  <= 1'b0;
      r_pred_target <= '0;
    end else begin
      r_pred_valid  <= bus.lu_valid;
      r_pred_hit    <= w_pred_hit;
      r_pred_taken  <= w_pred_hit && w_lu_sel_msb;
      r_pred_target <= w_pred_hit ? w_lu_sel_tgt : '0;
    end
  end

  assign bus.pred_valid  = r_pred_valid;
  assign bus.pred_hit    = r_pred_hit;
  assign bus.pred_taken  = r_pred_taken;
  assign bus.pred_target = r_pred_target;

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v,
                                                input logic              en);
    return (en && (v != '1)) ? v + STAT_W'(1) : v;
  endfunction

  logic w_is_br;
  logic w_mispr;

  assign w_is_br = bus.up_valid && bus.up_is_br;
  assign w_mispr = w_is_br && (bus.up_pred_taken != bus.up_taken);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt    <= '0;
      hit_cnt   <= '0;
      mispr_cnt <= '0;
    end else if (stat_clr) begin
      br_cnt    <= '0;
      hit_cnt   <= '0;
      mispr_cnt <= '0;
    end else begin
      br_cnt    <= sat_inc(br_cnt, w_is_br);
      hit_cnt   <= sat_inc(hit_cnt, r_pred_hit);
      mispr_cnt <= sat_inc(mispr_cnt, w_mispr);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_btb_assoc.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_btb_assoc : scoreboard bench for btb_assoc (SETS=256, WAYS=2, STAT_W=4)
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_btb_assoc;
  localparam int ADDR_W   = 16;
  localparam int SETS     = 256;
  localparam int WAYS     = 2;
  localparam int CTR_W    = 2;
  localparam int STAT_W   = 4;
  localparam int STAT_MAX = 15;
  localparam int CTR_MAX  = 3;

  logic              clk;
  logic              rst;
  logic              flush_all;
  logic              stat_clr;
  logic              busy;
  logic [STAT_W-1:0] br_cnt;
  logic [STAT_W-1:0] hit_cnt;
  logic [STAT_W-1:0] mispr_cnt;

  btb_assoc_if #(.ADDR_W(ADDR_W)) bus ();

  btb_assoc #(
    .ADDR_W(ADDR_W), .SETS(SETS), .WAYS(WAYS), .CTR_W(CTR_W), .STAT_W(STAT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .flush_all(flush_all),
    .busy     (busy),
    .stat_clr (stat_clr),
    .br_cnt   (br_cnt),
    .hit_cnt  (hit_cnt),
    .mispr_cnt(mispr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic        hit;
    logic        taken;
    logic [15:0] tgt;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model
  bit          m_vld [WAYS][SETS];
  logic [7:0]  m_tag [WAYS][SETS];
  int          m_ctr [WAYS][SETS];
  logic [15:0] m_tgt [WAYS][SETS];
  int          m_lru [SETS];
  int          sweep_left;
  int          m_br, m_hit, m_mispr;
  bit          m_prev_hit;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) m_vld[w][s] = 1'b0;
      m_lru[s] = 0;
    end
  endtask

  task automatic model_reset();
    model_clear();
    sweep_left = SETS;
    m_br = 0; m_hit = 0; m_mispr = 0;
    m_prev_hit = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_lookup(input logic [15:0] pc, output logic h, output logic t,
                              output logic [15:0] g);
    int s;
    s = int'(pc[7:0]);
    h = 1'b0; t = 1'b0; g = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!h && m_vld[w][s] && m_tag[w][s] == pc[15:8]) begin
        h = 1'b1;
        t = (m_ctr[w][s] >= 2);
        g = m_tgt[w][s];
      end
    end
  endtask

  task automatic model_update(input logic [15:0] pc, input logic taken, input logic [15:0] tgt);
    int s, hw, v;
    s  = int'(pc[7:0]);
    hw = -1;
    for (int w = 0; w < WAYS; w++)
      if (hw < 0 && m_vld[w][s] && m_tag[w][s] == pc[15:8]) hw = w;
    if (hw >= 0) begin
      if (taken) begin
        if (m_ctr[hw][s] < CTR_MAX) m_ctr[hw][s]++;
        m_tgt[hw][s] = tgt;
      end else if (m_ctr[hw][s] > 0) begin
        m_ctr[hw][s]--;
      end
      m_lru[s] = 1 - hw;
    end else if (taken) begin
      v = !m_vld[0][s] ? 0 : (!m_vld[1][s] ? 1 : m_lru[s]);
      m_vld[v][s] = 1'b1;
      m_tag[v][s] = pc[15:8];
      m_ctr[v][s] = 2;
      m_tgt[v][s] = tgt;
      m_lru[s]    = 1 - v;
    end
  endtask

  task automatic idle_inputs();
    bus.lu_valid = 1'b0; bus.lu_pc = '0;
    bus.up_valid = 1'b0; bus.up_is_br = 1'b0; bus.up_pc = '0;
    bus.up_taken = 1'b0; bus.up_target = '0; bus.up_pred_taken = 1'b0;
    flush_all = 1'b0; stat_clr = 1'b0;
  endtask

  // One clock: predict from current inputs, advance the model, then check.
  task automatic tick();
    logic        busy_now, eh, et;
    logic [15:0] eg;
    logic        is_br;
    busy_now = (sweep_left != 0);
    eh = 1'b0; et = 1'b0; eg = '0;
    if (bus.lu_valid) begin
      if (!busy_now) model_lookup(bus.lu_pc, eh, et, eg);
      exp_q.push_back('{due: cyc + 1, hit: eh, taken: et, tgt: eg});
    end
    is_br = bus.up_valid && bus.up_is_br;
    if (stat_clr) begin
      m_br = 0; m_hit = 0; m_mispr = 0;
    end else begin
      if (is_br && m_br < STAT_MAX) m_br++;
      if (m_prev_hit && m_hit < STAT_MAX) m_hit++;
      if (is_br && (bus.up_pred_taken != bus.up_taken) && m_mispr < STAT_MAX) m_mispr++;
    end
    m_prev_hit = bus.lu_valid && eh;
    if (!busy_now && is_br) model_update(bus.up_pc, bus.up_taken, bus.up_target);
    if (busy_now) sweep_left--;
    else if (flush_all) begin
      model_clear();
      sweep_left = SETS;
    end
    @(posedge clk);
    #1;
    check("busy", 32'(busy), 32'(sweep_left != 0));
    check("br_cnt", 32'(br_cnt), 32'(m_br));
    check("hit_cnt", 32'(hit_cnt), 32'(m_hit));
    check("mispr_cnt", 32'(mispr_cnt), 32'(m_mispr));
    idle_inputs();
  endtask

  task automatic set_update(input logic [15:0] pc, input logic taken, input logic [15:0] tgt,
                            input logic pt);
    bus.up_valid = 1'b1; bus.up_is_br = 1'b1; bus.up_pc = pc;
    bus.up_taken = taken; bus.up_target = tgt; bus.up_pred_taken = pt;
  endtask

  task automatic do_update(input logic [15:0] pc, input logic taken, input logic [15:0] tgt,
                           input logic pt);
    set_update(pc, taken, tgt, pt);
    tick();
  endtask

  task automatic do_lookup(input logic [15:0] pc);
    bus.lu_valid = 1'b1;
    bus.lu_pc    = pc;
    tick();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pred_valid"}, 32'(bus.pred_valid), 32'd0);
    check({tag, "_pred_hit"}, 32'(bus.pred_hit), 32'd0);
    check({tag, "_pred_target"}, 32'(bus.pred_target), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_br_cnt"}, 32'(br_cnt), 32'd0);
    check({tag, "_hit_cnt"}, 32'(hit_cnt), 32'd0);
    check({tag, "_mispr_cnt"}, 32'(mispr_cnt), 32'd0);
  endtask

  // Scoreboard: compare each registered prediction with its queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.pred_valid === 1'b1) begin
        if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
          check("pred_valid_unexpected", 32'(bus.pred_valid), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("pred_hit", 32'(bus.pred_hit), 32'(mon_e.hit));
          check("pred_taken", 32'(bus.pred_taken), 32'(mon_e.taken));
          check("pred_target", 32'(bus.pred_target), 32'(mon_e.tgt));
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        check("pred_valid", 32'(bus.pred_valid), 32'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pa;
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;
    model_reset();

    // Initial sweep, with a lookup issued while busy
    for (int i = 0; i < SETS; i++) begin
      if (i == 10) begin
        bus.lu_valid = 1'b1;
        bus.lu_pc    = 16'h1234;
      end
      tick();
    end
    check("busy_after_sweep", 32'(busy), 32'd0);
    do_lookup(16'h1234);

    // Allocate, then hysteresis on the same entry
    do_update(16'h0410, 1'b1, 16'h0800, 1'b0);
    do_lookup(16'h0410);
    check("br_after_alloc", 32'(br_cnt), 32'd1);
    do_update(16'h0410, 1'b0, 16'h0000, 1'b1); do_lookup(16'h0410);
    do_update(16'h0410, 1'b0, 16'h0000, 1'b0); do_lookup(16'h0410);
    do_update(16'h0410, 1'b1, 16'h0800, 1'b0); do_lookup(16'h0410);
    do_update(16'h0410, 1'b1, 16'h0800, 1'b0); do_lookup(16'h0410);
    do_update(16'h0410, 1'b1, 16'h0800, 1'b1); do_lookup(16'h0410);
    do_update(16'h0410, 1'b1, 16'h0804, 1'b1); do_lookup(16'h0410);

    // LRU: A, B in set 0x10, touch A, C evicts B
    do_update(16'h0110, 1'b1, 16'h1110, 1'b1);
    do_update(16'h0210, 1'b1, 16'h1210, 1'b1);
    do_update(16'h0110, 1'b1, 16'h1111, 1'b1);
    do_update(16'h0310, 1'b1, 16'h1310, 1'b1);
    do_lookup(16'h0110);
    do_lookup(16'h0210);
    do_lookup(16'h0310);

    // Same-cycle lookup and update to one set reads the old contents
    set_update(16'h0510, 1'b1, 16'h1510, 1'b1);
    bus.lu_valid = 1'b1;
    bus.lu_pc    = 16'h0510;
    tick();
    do_lookup(16'h0510);

    // Flush mid-run with updates and lookups during the sweep
    flush_all = 1'b1;
    tick();
    for (int i = 0; i < SETS; i++) begin
      if (i % 16 == 3) set_update(16'h0620 + 16'(i), 1'b1, 16'h2000 + 16'(i), 1'b1);
      if (i % 16 == 7) begin
        bus.lu_valid = 1'b1;
        bus.lu_pc    = 16'h0410;
      end
      if (i == 100) flush_all = 1'b1;
      tick();
    end
    check("busy_after_flush", 32'(busy), 32'd0);
    do_lookup(16'h0410);
    do_lookup(16'h0310);
    do_lookup(16'h0623);

    // Statistics saturation and clear priority
    stat_clr = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) do_update(16'h0700, 1'b0, 16'h0000, 1'b1);
    check("mispr_saturated", 32'(mispr_cnt), 32'd15);
    check("br_saturated", 32'(br_cnt), 32'd15);
    do_update(16'h0410, 1'b1, 16'h0900, 1'b1);
    do_lookup(16'h0410);
    set_update(16'h0700, 1'b0, 16'h0000, 1'b1);
    stat_clr = 1'b1;
    tick();
    check("clr_br", 32'(br_cnt), 32'd0);
    check("clr_hit", 32'(hit_cnt), 32'd0);
    check("clr_mispr", 32'(mispr_cnt), 32'd0);

    // Random mix over two contended sets
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) != 0) begin
        bus.lu_valid = 1'b1;
        bus.lu_pc    = {8'($urandom_range(1, 4)), ($urandom_range(0, 1) != 0) ? 8'h30 : 8'h31};
      end
      if ($urandom_range(0, 1) != 0) begin
        pa = {8'($urandom_range(1, 4)), ($urandom_range(0, 1) != 0) ? 8'h30 : 8'h31};
        set_update(pa, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
        bus.up_is_br = ($urandom_range(0, 7) != 0);
      end
      stat_clr = ($urandom_range(0, 39) == 0);
      tick();
    end

    // Asynchronous reset mid-operation
    do_update(16'h0440, 1'b1, 16'h4400, 1'b1);
    tick();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < SETS; i++) tick();
    do_lookup(16'h0440);
    do_lookup(16'h0130);

    repeat (2) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
